// File: rtl/rx_char_process.sv
// rx_char_process: receive-side character processor.
// Classifies decoded characters, resolves ESC sequences (NULL, time-code,
// escape error), queues N-chars in a first-word-fall-through FIFO, tracks the
// receive credit granted to the far end and keeps sticky error flags.
module rx_char_process #(
  parameter int FIFO_AW     = 3,
  parameter int CREDIT_W    = 6,
  parameter int CREDIT_STEP = 8,
  parameter int CREDIT_MAX  = 56
) (
  input  logic                posedge_clk,
  input  logic                rx_reset,
  input  logic                char_valid,
  input  logic                char_is_ctrl,
  input  logic [1:0]          char_ctrl,
  input  logic [7:0]          char_data,
  input  logic                char_par_err,
  input  logic                fct_sent,
  input  logic                err_clr,
  input  logic                rx_data_ready,
  output logic [8:0]          rx_data_flag,
  output logic                rx_data_valid,
  output logic [FIFO_AW:0]    fifo_count,
  output logic [7:0]          timecode,
  output logic                tick_out,
  output logic                rx_got_fct,
  output logic                rx_got_null,
  output logic [CREDIT_W-1:0] credit,
  output logic                err_par,
  output logic                err_esc,
  output logic                err_credit,
  output logic                err_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [CREDIT_W:0] STEP_EXT = (CREDIT_W+1)'(CREDIT_STEP);
  localparam logic [CREDIT_W:0] MAX_EXT  = (CREDIT_W+1)'(CREDIT_MAX);

  localparam logic [1:0] CTRL_FCT = 2'd0;
  localparam logic [1:0] CTRL_EOP = 2'd1;
  localparam logic [1:0] CTRL_EEP = 2'd2;
  localparam logic [1:0] CTRL_ESC = 2'd3;

  typedef enum logic {IDLE, ESC_PEND} state_t;

  state_t                state_reg, state_next;
  logic [8:0]            mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [FIFO_AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [FIFO_AW:0]      count_reg, count_next;
  logic [8:0]            head_reg, head_next;
  logic                  valid_reg;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [7:0]            timecode_reg;
  logic                  tick_reg, got_fct_reg, got_null_reg;
  logic                  err_par_reg, err_esc_reg, err_credit_reg, err_ovf_reg;

  logic                  char_ok, nchar, push_req, push_acc, pop, full;
  logic                  par_evt, esc_evt, credit_evt, ovf_evt;
  logic                  fct_evt, null_evt, tick_evt;
  logic [8:0]            push_word;
  logic [CREDIT_W:0]     credit_sum, credit_added;

  // Character decode, credit arithmetic and FIFO bookkeeping for this cycle.
  always_comb begin
    char_ok   = char_valid & ~char_par_err;
    par_evt   = char_valid & char_par_err;
    // N-chars are data, EOP and EEP seen outside an escape sequence.
    nchar     = char_ok && (state_reg == IDLE) &&
                (!char_is_ctrl || char_ctrl == CTRL_EOP || char_ctrl == CTRL_EEP);
    push_word = char_is_ctrl ? {1'b1, 7'd0, (char_ctrl == CTRL_EEP)}
                             : {1'b0, char_data};

    fct_evt   = char_ok && (state_reg == IDLE) && char_is_ctrl && (char_ctrl == CTRL_FCT);
    null_evt  = char_ok && (state_reg == ESC_PEND) && char_is_ctrl && (char_ctrl == CTRL_FCT);
    tick_evt  = char_ok && (state_reg == ESC_PEND) && !char_is_ctrl;
    esc_evt   = char_ok && (state_reg == ESC_PEND) && char_is_ctrl && (char_ctrl != CTRL_FCT);

    // Credit granted by an FCT sent this cycle is usable by a same-cycle N-char.
    credit_sum   = {1'b0, credit_reg} + STEP_EXT;
    if (fct_sent)
      credit_added = (credit_sum > MAX_EXT) ? MAX_EXT : credit_sum;
    else
      credit_added = {1'b0, credit_reg};

    push_req    = nchar && (credit_added != '0);
    credit_evt  = nchar && (credit_added == '0);
    credit_next = push_req ? CREDIT_W'(credit_added - 1'b1) : CREDIT_W'(credit_added);

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    pop      = valid_reg && rx_data_ready;
    full     = (count_reg == FULL_CNT);
    push_acc = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;

    rd_ptr_next = rd_ptr_reg + FIFO_AW'(pop);
    wr_ptr_next = wr_ptr_reg + FIFO_AW'(push_acc);
    count_next  = count_reg + (FIFO_AW+1)'(push_acc) - (FIFO_AW+1)'(pop);

    // Registered head: bypass the write when the new entry becomes the head.
    if (count_next == '0)
      head_next = 9'd0;
    else if (push_acc && (wr_ptr_reg == rd_ptr_next))
      head_next = push_word;
    else
      head_next = mem[rd_ptr_next];

    state_next = state_reg;
    if (char_valid) begin
      if (char_par_err)
        state_next = IDLE;
      else if (state_reg == IDLE && char_is_ctrl && char_ctrl == CTRL_ESC)
        state_next = ESC_PEND;
      else
        state_next = IDLE;
    end
  end

  // FIFO storage; no reset so it maps onto plain RAM.
  always_ff @(posedge posedge_clk) begin
    if (push_acc)
      mem[wr_ptr_reg] <= push_word;
  end

  // State, FIFO pointers, credit, time-code, pulses and sticky errors.
  always_ff @(posedge posedge_clk) begin
    if (rx_reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_reg       <= 9'd0;
      valid_reg      <= 1'b0;
      credit_reg     <= '0;
      timecode_reg   <= 8'd0;
      tick_reg       <= 1'b0;
      got_fct_reg    <= 1'b0;
      got_null_reg   <= 1'b0;
      err_par_reg    <= 1'b0;
      err_esc_reg    <= 1'b0;
      err_credit_reg <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_reg       <= head_next;
      valid_reg      <= (count_next != '0);
      credit_reg     <= credit_next;
      if (tick_evt)
        timecode_reg <= char_data;
      tick_reg       <= tick_evt;
      got_fct_reg    <= fct_evt;
      got_null_reg   <= null_evt;
      // A new error event wins over a simultaneous clear.
      err_par_reg    <= (err_par_reg    & ~err_clr) | par_evt;
      err_esc_reg    <= (err_esc_reg    & ~err_clr) | esc_evt;
      err_credit_reg <= (err_credit_reg & ~err_clr) | credit_evt;
      err_ovf_reg    <= (err_ovf_reg    & ~err_clr) | ovf_evt;
    end
  end

  assign rx_data_flag  = head_reg;
  assign rx_data_valid = valid_reg;
  assign fifo_count    = count_reg;
  assign timecode      = timecode_reg;
  assign tick_out      = tick_reg;
  assign rx_got_fct    = got_fct_reg;
  assign rx_got_null   = got_null_reg;
  assign credit        = credit_reg;
  assign err_par       = err_par_reg;
  assign err_esc       = err_esc_reg;
  assign err_credit    = err_credit_reg;
  assign err_ovf       = err_ovf_reg;

endmodule

// File: tb/tb_rx_char_process.sv
// tb_rx_char_process: directed, table-driven bench for rx_char_process.
module tb_rx_char_process;

  logic       posedge_clk = 1'b0;
  logic       rx_reset;
  logic       char_valid, char_is_ctrl, char_par_err, fct_sent, err_clr, rx_data_ready;
  logic [1:0] char_ctrl;
  logic [7:0] char_data;
  logic [8:0] rx_data_flag;
  logic       rx_data_valid;
  logic [3:0] fifo_count;
  logic [7:0] timecode;
  logic       tick_out, rx_got_fct, rx_got_null;
  logic [5:0] credit;
  logic       err_par, err_esc, err_credit, err_ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FCT = 2'd0, EOP = 2'd1, EEP = 2'd2, ESC = 2'd3;

  rx_char_process #(.FIFO_AW(3), .CREDIT_W(6), .CREDIT_STEP(8), .CREDIT_MAX(56)) dut (
    .posedge_clk(posedge_clk), .rx_reset(rx_reset),
    .char_valid(char_valid), .char_is_ctrl(char_is_ctrl), .char_ctrl(char_ctrl),
    .char_data(char_data), .char_par_err(char_par_err), .fct_sent(fct_sent),
    .err_clr(err_clr), .rx_data_ready(rx_data_ready),
    .rx_data_flag(rx_data_flag), .rx_data_valid(rx_data_valid), .fifo_count(fifo_count),
    .timecode(timecode), .tick_out(tick_out), .rx_got_fct(rx_got_fct),
    .rx_got_null(rx_got_null), .credit(credit),
    .err_par(err_par), .err_esc(err_esc), .err_credit(err_credit), .err_ovf(err_ovf)
  );

  always #5 posedge_clk = ~posedge_clk;

  typedef struct {
    logic       cv, ctl;
    logic [1:0] code;
    logic [7:0] data;
    logic       perr, fs, clr, rdy;
    logic       vld;
    logic [8:0] flag;
    logic [3:0] cnt;
    logic [5:0] cred;
    logic [7:0] tc;
    logic       tick, gfct, gnull;
    logic [3:0] errs;   // {par, esc, credit, ovf}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cv, ctl, input logic [1:0] code, input logic [7:0] data,
                              input logic perr, fs, clr, rdy, vld, input logic [8:0] flag,
                              input logic [3:0] cnt, input logic [5:0] cred, input logic [7:0] tc,
                              input logic tick, gfct, gnull, input logic [3:0] errs);
    vec_t v;
    v.cv = cv; v.ctl = ctl; v.code = code; v.data = data; v.perr = perr; v.fs = fs;
    v.clr = clr; v.rdy = rdy; v.vld = vld; v.flag = flag; v.cnt = cnt; v.cred = cred;
    v.tc = tc; v.tick = tick; v.gfct = gfct; v.gnull = gnull; v.errs = errs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic apply(input logic rst, cv, ctl, input logic [1:0] code, input logic [7:0] data,
                       input logic perr, fs, clr, rdy);
    rx_reset = rst; char_valid = cv; char_is_ctrl = ctl; char_ctrl = code; char_data = data;
    char_par_err = perr; fct_sent = fs; err_clr = clr; rx_data_ready = rdy;
    @(posedge posedge_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t e);
    chk({tag, ".valid"},  32'(rx_data_valid), 32'(e.vld));
    chk({tag, ".flag"},   32'(rx_data_flag),  32'(e.flag));
    chk({tag, ".count"},  32'(fifo_count),    32'(e.cnt));
    chk({tag, ".credit"}, 32'(credit),        32'(e.cred));
    chk({tag, ".tc"},     32'(timecode),      32'(e.tc));
    chk({tag, ".tick"},   32'(tick_out),      32'(e.tick));
    chk({tag, ".fct"},    32'(rx_got_fct),    32'(e.gfct));
    chk({tag, ".null"},   32'(rx_got_null),   32'(e.gnull));
    chk({tag, ".errs"},   32'({err_par, err_esc, err_credit, err_ovf}), 32'(e.errs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   c;
    logic [8:0] expq[$];

    // cv ctl code data perr fs clr rdy | vld flag cnt cred tc tick fct null errs
    vecs.push_back(mk(0,0,FCT,8'h00,0,1,0,0, 0,9'h000,0,8,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h41,0,0,0,0, 1,9'h041,1,7,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h42,0,0,0,0, 1,9'h041,2,6,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,EOP,8'h00,0,0,0,0, 1,9'h041,3,5,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,0,1, 1,9'h042,2,5,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,0,1, 1,9'h100,1,5,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,0,1, 0,9'h000,0,5,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,ESC,8'h00,0,0,0,0, 0,9'h000,0,5,8'h00,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h3F,0,0,0,0, 0,9'h000,0,5,8'h3F,1,0,0,4'b0000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,ESC,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,FCT,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,1,4'b0000));
    vecs.push_back(mk(1,1,FCT,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,1,0,4'b0000));
    vecs.push_back(mk(1,1,FCT,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,1,0,4'b0000));
    vecs.push_back(mk(1,1,ESC,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,EOP,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0100));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,1,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,ESC,8'h00,0,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h77,1,0,0,0, 0,9'h000,0,5,8'h3F,0,0,0,4'b1000));
    vecs.push_back(mk(1,0,FCT,8'h10,0,0,0,0, 1,9'h010,1,4,8'h3F,0,0,0,4'b1000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,1,1, 0,9'h000,0,4,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h01,0,0,0,1, 1,9'h001,1,3,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h02,0,0,0,1, 1,9'h002,1,2,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h03,0,0,0,1, 1,9'h003,1,1,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h04,0,0,0,1, 1,9'h004,1,0,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,FCT,8'h55,0,0,0,1, 0,9'h000,0,0,8'h3F,0,0,0,4'b0010));
    vecs.push_back(mk(1,0,FCT,8'h66,0,0,1,0, 0,9'h000,0,0,8'h3F,0,0,0,4'b0010));
    vecs.push_back(mk(1,0,FCT,8'h77,0,1,0,0, 1,9'h077,1,7,8'h3F,0,0,0,4'b0010));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,1,1, 0,9'h000,0,7,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,EEP,8'h00,0,0,0,0, 1,9'h101,1,6,8'h3F,0,0,0,4'b0000));
    vecs.push_back(mk(0,0,FCT,8'h00,0,0,0,1, 0,9'h000,0,6,8'h3F,0,0,0,4'b0000));

    // Reset for two cycles with garbage on the inputs; reset must dominate.
    apply(1, 1,0,FCT,8'hAB, 0,1,0,1);
    apply(1, 1,1,ESC,8'h00, 0,1,0,1);
    e = mk(0,0,FCT,8'h00,0,0,0,0, 0,9'h000,0,0,8'h00,0,0,0,4'b0000);
    check_all("reset", e);
    $display("reset: count=%0d credit=%0d", fifo_count, credit);

    foreach (vecs[i]) begin
      apply(0, vecs[i].cv, vecs[i].ctl, vecs[i].code, vecs[i].data,
            vecs[i].perr, vecs[i].fs, vecs[i].clr, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i]);
      $display("vec %0d: flag=%h count=%0d credit=%0d errs=%b", i, rx_data_flag, fifo_count,
               credit, {err_par, err_esc, err_credit, err_ovf});
    end

    // Credit saturation: credit 6, eight FCTs sent.
    c = 6;
    for (int k = 0; k < 8; k++) begin
      apply(0, 0,0,FCT,8'h00, 0,1,0,0);
      c = (c + 8 > 56) ? 56 : c + 8;
      chk($sformatf("sat%0d.credit", k), 32'(credit), 32'(c));
      $display("fct_sent %0d: credit=%0d", k, credit);
    end

    // Overflow: nine pushes with the consumer stalled.
    for (int k = 0; k < 9; k++) begin
      apply(0, 1,0,FCT,8'(8'h80 + k), 0,0,0,0);
      chk($sformatf("ovf%0d.count", k), 32'(fifo_count), (k < 8) ? 32'(k + 1) : 32'd8);
      chk($sformatf("ovf%0d.err_ovf", k), 32'(err_ovf), (k < 8) ? 32'd0 : 32'd1);
      $display("push %0d: count=%0d err_ovf=%0d credit=%0d", k, fifo_count, err_ovf, credit);
    end
    chk("ovf.credit", 32'(credit), 32'd47);
    chk("ovf.head", 32'(rx_data_flag), 32'h080);
    apply(0, 0,0,FCT,8'h00, 0,0,1,0);
    chk("ovfclr.err_ovf", 32'(err_ovf), 32'd0);

    // Push at full with a simultaneous pop is accepted.
    apply(0, 1,0,FCT,8'hAA, 0,0,0,1);
    chk("fullpop.count", 32'(fifo_count), 32'd8);
    chk("fullpop.err_ovf", 32'(err_ovf), 32'd0);
    chk("fullpop.credit", 32'(credit), 32'd46);
    $display("push at full with pop: count=%0d err_ovf=%0d", fifo_count, err_ovf);

    // Drain and confirm FIFO order across the pointer wrap.
    for (int k = 1; k < 8; k++) expq.push_back(9'(9'h080 + k));
    expq.push_back(9'h0AA);
    foreach (expq[k]) begin
      chk($sformatf("drain%0d.valid", k), 32'(rx_data_valid), 32'd1);
      chk($sformatf("drain%0d.flag", k), 32'(rx_data_flag), 32'(expq[k]));
      $display("pop %0d: flag=%h", k, rx_data_flag);
      apply(0, 0,0,FCT,8'h00, 0,0,0,1);
    end
    chk("drained.valid", 32'(rx_data_valid), 32'd0);
    chk("drained.count", 32'(fifo_count), 32'd0);

    // Mid-stream reset with queued data, a sticky error and a pending ESC.
    apply(0, 1,0,FCT,8'h99, 1,0,0,0);
    for (int k = 0; k < 4; k++) apply(0, 1,0,FCT,8'(8'h20 + k), 0,0,0,0);
    apply(0, 1,1,ESC,8'h00, 0,0,0,0);
    chk("pre_rst.count", 32'(fifo_count), 32'd4);
    chk("pre_rst.credit", 32'(credit), 32'd42);
    chk("pre_rst.err_par", 32'(err_par), 32'd1);
    apply(1, 1,0,FCT,8'h33, 0,1,0,0);
    e = mk(0,0,FCT,8'h00,0,0,0,0, 0,9'h000,0,0,8'h00,0,0,0,4'b0000);
    check_all("midrst", e);
    $display("mid-stream reset: count=%0d credit=%0d", fifo_count, credit);
    apply(0, 1,0,FCT,8'h12, 0,0,0,0);
    e = mk(0,0,FCT,8'h00,0,0,0,0, 0,9'h000,0,0,8'h00,0,0,0,4'b0010);
    check_all("postrst", e);
    $display("data after reset: err_credit=%0d tick=%0d", err_credit, tick_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_char_process.md
Name: rx_char_process

Overview:
- Parametrised successor of the SpaceWire receive-side character processor; sits between the RX bit decoder and the host/FSM side.
- Classifies decoded characters and detects ESC sequences (NULL, time-code, escape error).
- Buffers N-chars (data/EOP/EEP) in a 9-bit first-word-fall-through FIFO with valid/ready output, tracks receive credit, and keeps sticky error flags per ECSS-E-ST-50-12C.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 9 bits
CREDIT_W, 6, width of credit counter
CREDIT_STEP, 8, credit added per FCT sent by local transmitter
CREDIT_MAX, 56, credit saturation value (must be < 2**CREDIT_W)

Ports:
posedge_clk  in  1  clock (single clock domain)
rx_reset  in  1  synchronous, active-high reset
char_valid  in  1  one-cycle strobe: decoded character present
char_is_ctrl  in  1  1 = control char, 0 = data char
char_ctrl  in  2  control code: 0 FCT, 1 EOP, 2 EEP, 3 ESC
char_data  in  8  data byte (valid when char_is_ctrl = 0)
char_par_err  in  1  upstream parity check failed for this char
fct_sent  in  1  one-cycle strobe: local TX sent an FCT
err_clr  in  1  clears all sticky error flags
rx_data_ready  in  1  consumer accepts FIFO head
rx_data_flag  out  9  FIFO head: {0,byte}, 9'h100 EOP, 9'h101 EEP
rx_data_valid  out  1  FIFO not empty
fifo_count  out  FIFO_AW+1  occupancy
timecode  out  8  last received time-code
tick_out  out  1  one-cycle pulse on new time-code
rx_got_fct  out  1  one-cycle pulse on FCT
rx_got_null  out  1  one-cycle pulse on NULL (ESC+FCT)
credit  out  CREDIT_W  remaining N-chars the far end may send
err_par, err_esc, err_credit, err_ovf  out  1 each  sticky errors

Behaviour:
- Reset (sync, rx_reset = 1 at clock edge): state IDLE, FIFO empty, fifo_count 0, rx_data_valid 0, rx_data_flag 0, timecode 0, credit 0, all pulses and errors 0. Reset dominates every other input in that cycle.
- Two-state FSM: IDLE, ESC_PEND. Only characters with char_valid = 1 are processed. Outputs are registered: char at edge n gives its pulse/flag/FIFO effect visible after edge n.
- IDLE transitions:
  - FCT: rx_got_fct pulse.
  - EOP: push 9'h100.
  - EEP: push 9'h101.
  - Data: push {1'b0, char_data}.
  - ESC: go to ESC_PEND.
- ESC_PEND transitions (always return to IDLE):
  - FCT: rx_got_null pulse, no rx_got_fct.
  - Data: timecode <= char_data, tick_out pulse, no push, no credit use.
  - ESC/EOP/EEP: set err_esc, char discarded.
- Parity: char_par_err = 1 sets err_par, discards the char, forces IDLE (cancels a pending ESC).
- Credit (N-chars = data/EOP/EEP pushed from IDLE):
  - An N-char arriving at credit 0 sets err_credit; the char is discarded, credit stays 0.
  - Otherwise the N-char consumes 1 credit.
  - fct_sent adds CREDIT_STEP, saturating at CREDIT_MAX.
  - Same-cycle fct_sent and N-char: credit = min(credit + CREDIT_STEP, CREDIT_MAX) - 1, and the N-char is accepted even if credit was 0.
- FIFO:
  - Pop when rx_data_valid & rx_data_ready.
  - Push at full sets err_ovf and drops the char (credit still consumed), unless a pop occurs in the same cycle, in which case the push is accepted.
  - Push into empty: rx_data_valid = 1 next cycle with that entry on rx_data_flag.
  - Pointers wrap modulo depth; fifo_count is exact, range 0..2**FIFO_AW.
- Sticky errors: set stays set until err_clr. If err_clr and a new error event coincide, the flag ends up 1. Errors do not stop processing.
- tick_out, rx_got_fct, rx_got_null are high for exactly one cycle per event; back-to-back events give consecutive pulses.

Test Plan:
- Reset, fct_sent once, then data 0x41, 0x42, EOP -> FIFO reads 9'h041, 9'h042, 9'h100; credit 8 -> 5; no errors.
- ESC then data 0x3F -> timecode = 0x3F, one tick_out pulse, fifo_count unchanged, credit unchanged. ESC then FCT -> one rx_got_null pulse, rx_got_fct stays 0.
- ESC then EOP -> err_esc = 1, FIFO unchanged. err_clr -> err_esc = 0. ESC then data with char_par_err -> err_par = 1, no tick_out; next data 0x10 is pushed as 9'h010.
- Credit 0 and data 0x55 -> err_credit = 1, nothing pushed. Eight fct_sent pulses -> credit saturates at 56. fct_sent together with data at credit 0 -> data accepted, credit = 7.
- FIFO_AW = 3, rx_data_ready = 0, credit 56, send 9 data chars -> fifo_count = 8, err_ovf = 1, credit = 47. Push at full with ready = 1 in the same cycle -> accepted, no err_ovf.
- Assert rx_reset mid-stream with 4 entries queued and ESC pending -> next cycle fifo_count 0, credit 0, errors 0. Following data char at credit 0 -> err_credit (pending ESC was cleared).
